// File: rtl/mmio_uart_tx_pkg.sv
// Shared constants for the MMIO UART transmitter: register offsets,
// STATUS/CTRL bit positions and serialiser state encodings.
package mmio_uart_tx_pkg;

   localparam logic [1:0] UART_OFF_TXDATA = 2'd0;
   localparam logic [1:0] UART_OFF_STATUS = 2'd1;
   localparam logic [1:0] UART_OFF_DIV    = 2'd2;
   localparam logic [1:0] UART_OFF_CTRL   = 2'd3;

   localparam int UART_STAT_FULL  = 0;
   localparam int UART_STAT_EMPTY = 1;
   localparam int UART_STAT_BUSY  = 2;
   localparam int UART_STAT_OVF   = 3;
   localparam int UART_STAT_CNT   = 8;

   localparam int UART_CTRL_TXEN  = 0;
   localparam int UART_CTRL_IRQEN = 1;

   typedef enum logic [1:0] {
      UART_ST_IDLE  = 2'd0,
      UART_ST_START = 2'd1,
      UART_ST_DATA  = 2'd2,
      UART_ST_STOP  = 2'd3
   } uart_state_e;

   // A zero divisor still needs one cycle per bit
   function automatic logic [15:0] uart_bit_len(input logic [15:0] div);
      return (div == 16'd0) ? 16'd1 : div;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART serialiser.
// A push into a full FIFO is accepted only when a pop lands in the same cycle.
module uart_tx_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [7:0]               i_din,
   input  logic                     i_pop,
   output logic [7:0]               o_dout,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = 1;
   localparam logic [AW:0]   CNT_ONE  = 1;
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_full    = (r_count == CNT_FULL);
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_dout    = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         unique case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: register decode, TX FIFO and 8N1 serialiser.
// Define UART_TX_IRQ_EN to add the o_irq port and CTRL[1] irq_en.
module mmio_uart_tx
   import mmio_uart_tx_pkg::*;
#(
   parameter logic [29:0] BASE_ADDR  = 30'h0,
   parameter int          FIFO_DEPTH = 16,
   parameter logic [15:0] DIV_RESET  = 16'd434
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [29:0] i_mmio_addr,
   input  logic [31:0] i_mmio_data,
   input  logic [3:0]  i_mmio_mask,
   input  logic        i_mmio_wren,
   output logic [31:0] o_mmio_data,
`ifdef UART_TX_IRQ_EN
   output logic        o_irq,
`endif
   output logic        o_tx
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic          w_hit;
   logic [1:0]    w_off;
   logic          w_wr;
   logic          w_push;
   logic          w_pop;
   logic          w_can_pop;
   logic          w_ovf_set;
   logic          w_ovf_clr;
   logic [7:0]    w_dout;
   logic          w_full;
   logic          w_empty;
   logic [CW-1:0] w_count;
   logic [7:0]    w_cnt8;
   logic          w_busy;
   logic          w_bit_done;
   logic [31:0]   w_status;
   logic [31:0]   w_ctrl;
   logic          w_unused;

   logic [15:0]   r_div;
   logic          r_tx_en;
   logic          r_ovf;
   logic [7:0]    r_shift;
   logic [15:0]   r_bit_len;
   logic [15:0]   r_cnt;
   logic [2:0]    r_idx;

   uart_state_e   r_state;
   uart_state_e   w_state_nxt;

   assign w_hit  = (i_mmio_addr[29:2] == BASE_ADDR[29:2]);
   assign w_off  = i_mmio_addr[1:0];
   assign w_wr   = w_hit & i_mmio_wren;
   assign w_push = w_wr & (w_off == UART_OFF_TXDATA) & i_mmio_mask[0];

   assign w_ovf_set = w_push & w_full & ~w_pop;
   assign w_ovf_clr = w_wr & (w_off == UART_OFF_STATUS)
                      & i_mmio_mask[0] & i_mmio_data[UART_STAT_OVF];

   assign w_busy     = (r_state != UART_ST_IDLE);
   assign w_bit_done = (r_cnt == r_bit_len - 16'd1);
   assign w_can_pop  = r_tx_en & ~w_empty;

   // Popping from the last STOP cycle keeps frames back-to-back
   assign w_pop = w_can_pop & ((r_state == UART_ST_IDLE)
                  | ((r_state == UART_ST_STOP) & w_bit_done));

   assign w_cnt8   = 8'(w_count);
   assign w_unused = ^{i_mmio_data[31:16], i_mmio_mask[3:2]};

   uart_tx_fifo #(
      .DEPTH   (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_din   (i_mmio_data[7:0]),
      .i_pop   (w_pop),
      .o_dout  (w_dout),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (w_ovf_set) begin
         r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
         r_ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div <= DIV_RESET;
      end else if (w_wr && w_off == UART_OFF_DIV) begin
         if (i_mmio_mask[0]) r_div[7:0]  <= i_mmio_data[7:0];
         if (i_mmio_mask[1]) r_div[15:8] <= i_mmio_data[15:8];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tx_en <= 1'b1;
      end else if (w_wr && w_off == UART_OFF_CTRL && i_mmio_mask[0]) begin
         r_tx_en <= i_mmio_data[UART_CTRL_TXEN];
      end
   end

`ifdef UART_TX_IRQ_EN
   logic r_irq_en;
   logic r_irq;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_irq_en <= 1'b0;
      end else if (w_wr && w_off == UART_OFF_CTRL && i_mmio_mask[0]) begin
         r_irq_en <= i_mmio_data[UART_CTRL_IRQEN];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= r_irq_en & w_empty & ~w_busy;
      end
   end

   assign o_irq = r_irq;
`endif

   always_comb begin
      w_ctrl = '0;
      w_ctrl[UART_CTRL_TXEN] = r_tx_en;
`ifdef UART_TX_IRQ_EN
      w_ctrl[UART_CTRL_IRQEN] = r_irq_en;
`endif
   end

   always_comb begin
      w_status = '0;
      w_status[UART_STAT_FULL]  = w_full;
      w_status[UART_STAT_EMPTY] = w_empty;
      w_status[UART_STAT_BUSY]  = w_busy;
      w_status[UART_STAT_OVF]   = r_ovf;
      w_status[UART_STAT_CNT +: 8] = w_cnt8;
   end

   always_comb begin
      o_mmio_data = '0;
      if (w_hit) begin
         unique case (w_off)
            UART_OFF_TXDATA: o_mmio_data = '0;
            UART_OFF_STATUS: o_mmio_data = w_status;
            UART_OFF_DIV:    o_mmio_data = {16'd0, r_div};
            UART_OFF_CTRL:   o_mmio_data = w_ctrl;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= UART_ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         UART_ST_IDLE:
            if (w_pop) w_state_nxt = UART_ST_START;
         UART_ST_START:
            if (w_bit_done) w_state_nxt = UART_ST_DATA;
         UART_ST_DATA:
            if (w_bit_done && r_idx == 3'd7) w_state_nxt = UART_ST_STOP;
         UART_ST_STOP:
            if (w_bit_done) w_state_nxt = w_pop ? UART_ST_START : UART_ST_IDLE;
      endcase
   end

   always_comb begin
      o_tx = 1'b1;
      unique case (r_state)
         UART_ST_IDLE:  o_tx = 1'b1;
         UART_ST_START: o_tx = 1'b0;
         UART_ST_DATA:  o_tx = r_shift[0];
         UART_ST_STOP:  o_tx = 1'b1;
      endcase
   end

   // Bit timing and shift register; bit_len is frozen for the whole frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shift   <= '0;
         r_bit_len <= 16'd1;
         r_cnt     <= '0;
         r_idx     <= '0;
      end else if (w_pop) begin
         r_shift   <= w_dout;
         r_bit_len <= uart_bit_len(r_div);
         r_cnt     <= '0;
         r_idx     <= '0;
      end else if (w_busy) begin
         if (w_bit_done) begin
            r_cnt <= '0;
            if (r_state == UART_ST_DATA) begin
               r_shift <= r_shift >> 1;
               r_idx   <= r_idx + 3'd1;
            end
         end else begin
            r_cnt <= r_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed + randomized bench for mmio_uart_tx against a queue-based
// model of the register map and 8N1 frame timing.
module tb_mmio_uart_tx;

   localparam logic [29:0] BASE = 30'h100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [29:0] i_mmio_addr = '0;
   logic [31:0] i_mmio_data = '0;
   logic [3:0]  i_mmio_mask = '0;
   logic        i_mmio_wren = 1'b0;
   logic [31:0] o_mmio_data;
   logic        o_tx;
`ifdef UART_TX_IRQ_EN
   logic        o_irq;
`endif

   int nvec = 0;
   int nerr = 0;

   logic [15:0] mdiv = 16'd434;
   logic        movf = 1'b0;
   logic [7:0]  mq [$];

   mmio_uart_tx #(
      .BASE_ADDR   (BASE),
      .FIFO_DEPTH  (16),
      .DIV_RESET   (16'd434)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_mmio_addr (i_mmio_addr),
      .i_mmio_data (i_mmio_data),
      .i_mmio_mask (i_mmio_mask),
      .i_mmio_wren (i_mmio_wren),
      .o_mmio_data (o_mmio_data),
`ifdef UART_TX_IRQ_EN
      .o_irq       (o_irq),
`endif
      .o_tx        (o_tx)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wra(input logic [29:0] a, input logic [31:0] d,
                      input logic [3:0] m);
      i_mmio_addr = a;
      i_mmio_data = d;
      i_mmio_mask = m;
      i_mmio_wren = 1'b1;
      @(negedge clk);
      i_mmio_wren = 1'b0;
   endtask

   task automatic wr(input logic [1:0] off, input logic [31:0] d,
                     input logic [3:0] m);
      wra(BASE | 30'(off), d, m);
   endtask

   task automatic rda(input logic [29:0] a, output logic [31:0] d);
      i_mmio_addr = a;
      i_mmio_wren = 1'b0;
      #1;
      d = o_mmio_data;
   endtask

   task automatic rd(input logic [1:0] off, output logic [31:0] d);
      rda(BASE | 30'(off), d);
   endtask

   function automatic logic [31:0] exp_status(input int cnt, input bit busy);
      logic [31:0] s;
      s = 32'(cnt) << 8;
      s[3] = movf;
      s[2] = busy;
      s[1] = (cnt == 0);
      s[0] = (cnt == 16);
      return s;
   endfunction

   function automatic int bl_of(input logic [15:0] d);
      return (d == 16'd0) ? 1 : int'(d);
   endfunction

   // cur = index of the frame sample at the present negedge, -1 if the
   // frame begins at the next one
   task automatic check_frame(input logic [7:0] b, input int bl,
                              input int cur);
      logic [31:0] st;
      int pos;
      logic e;
      for (int j = 0; j < 10 * bl; j++) begin
         if (j > cur) @(negedge clk);
         if (j >= cur) begin
            rd(2'd1, st);
            pos = j / bl;
            if (pos == 0)      e = 1'b0;
            else if (pos == 9) e = 1'b1;
            else               e = b[pos-1];
            chk("frame_tx", {31'd0, o_tx}, {31'd0, e});
            chk("frame_busy", {31'd0, st[2]}, 32'd1);
         end
      end
   endtask

   initial begin
      logic [31:0] r;
      logic [7:0]  b, h, x;
      int          lows;

      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      chk("rst_tx", {31'd0, o_tx}, 32'd1);
      rd(2'd1, r); chk("rst_status", r, 32'h2);
      rd(2'd2, r); chk("rst_div", r, 32'd434);
      rd(2'd3, r); chk("rst_ctrl", r, 32'd1);
      rd(2'd0, r); chk("rst_txdata", r, 32'd0);

      // Single frame, DIV=4, 0x55
      wr(2'd2, 32'd4, 4'b0011); mdiv = 16'd4;
      rd(2'd2, r); chk("div4", r, 32'd4);
      wr(2'd0, 32'h55, 4'b0001);
      check_frame(8'h55, 4, -1);
      @(negedge clk);
      rd(2'd1, r); chk("t1_status_after", r, 32'h2);

      // Per-lane DIV writes
      wr(2'd2, 32'h0000AB00, 4'b0010); mdiv = {8'hAB, mdiv[7:0]};
      rd(2'd2, r); chk("div_lane1", r, {16'd0, mdiv});
      wr(2'd2, 32'h00001203, 4'b0001); mdiv = {mdiv[15:8], 8'h03};
      rd(2'd2, r); chk("div_lane0", r, {16'd0, mdiv});
      wr(2'd0, 32'h77, 4'b1110);
      rd(2'd1, r); chk("txdata_nomask", r, 32'h2);

      // Randomized single frames
      repeat (4) begin
         mdiv = 16'($urandom_range(1, 5));
         b = 8'($urandom);
         wr(2'd2, {16'd0, mdiv}, 4'b0011);
         wr(2'd0, {24'd0, b}, 4'b0001);
         rd(2'd0, r); chk("txdata_rd0", r, 32'd0);
         check_frame(b, bl_of(mdiv), -1);
      end

      // Fill with tx disabled, overflow, clear, drain 16 in order
      mdiv = 16'($urandom_range(1, 2));
      wr(2'd2, {16'd0, mdiv}, 4'b0011);
      wr(2'd3, 32'd0, 4'b0001);
      for (int i = 0; i < 17; i++) begin
         b = 8'($urandom);
         wr(2'd0, {24'd0, b}, 4'b0001);
         if (mq.size() < 16) mq.push_back(b);
         else movf = 1'b1;
      end
      rd(2'd1, r); chk("t2_full_ovf", r, exp_status(mq.size(), 1'b0));
      wr(2'd1, 32'h8, 4'b0001); movf = 1'b0;
      rd(2'd1, r); chk("t2_ovf_clr", r, exp_status(mq.size(), 1'b0));
      wr(2'd3, 32'd1, 4'b0001);
      while (mq.size() > 0) check_frame(mq.pop_front(), bl_of(mdiv), -1);
      lows = 0;
      repeat (12) begin
         @(negedge clk);
         if (o_tx !== 1'b1) lows++;
      end
      chk("t2_no_extra_frame", 32'(lows), 32'd0);
      rd(2'd1, r); chk("t2_status_end", r, 32'h2);

      // Push lands on the pop edge of a full FIFO
      wr(2'd3, 32'd0, 4'b0001);
      for (int i = 0; i < 16; i++) begin
         b = 8'($urandom);
         wr(2'd0, {24'd0, b}, 4'b0001);
         mq.push_back(b);
      end
      rd(2'd1, r); chk("t3_full", r, exp_status(mq.size(), 1'b0));
      x = 8'($urandom);
      wr(2'd3, 32'd1, 4'b0001);
      wr(2'd0, {24'd0, x}, 4'b0001);
      h = mq.pop_front();
      mq.push_back(x);
      rd(2'd1, r); chk("t3_push_pop", r, exp_status(mq.size(), 1'b1));
      check_frame(h, bl_of(mdiv), 0);
      while (mq.size() > 0) check_frame(mq.pop_front(), bl_of(mdiv), -1);
      @(negedge clk);
      rd(2'd1, r); chk("t3_status_end", r, 32'h2);

      // DIV=0 then DIV=8 written during the first frame
      wr(2'd3, 32'd0, 4'b0001);
      wr(2'd2, 32'd0, 4'b0011); mdiv = 16'd0;
      b = 8'($urandom);
      h = 8'($urandom);
      wr(2'd0, {24'd0, b}, 4'b0001);
      wr(2'd0, {24'd0, h}, 4'b0001);
      wr(2'd3, 32'd1, 4'b0001);
      wr(2'd3, 32'd1, 4'b0001);
      wr(2'd2, 32'd8, 4'b0011);
      check_frame(b, bl_of(mdiv), 1);
      mdiv = 16'd8;
      check_frame(h, bl_of(mdiv), -1);
      @(negedge clk);
      rd(2'd1, r); chk("t4_status_end", r, 32'h2);

      // Reset during DATA with bytes still queued
      wr(2'd2, 32'd4, 4'b0011);
      wr(2'd3, 32'd0, 4'b0001);
      wr(2'd0, 32'h00, 4'b0001);
      repeat (3) wr(2'd0, 32'($urandom_range(0, 255)), 4'b0001);
      wr(2'd3, 32'd1, 4'b0001);
      repeat (6) @(negedge clk);
      chk("t5_pre_rst_data", {31'd0, o_tx}, 32'd0);
      #1 rst = 1'b1;
      #1 chk("t5_rst_tx", {31'd0, o_tx}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      mdiv = 16'd434;
      mq.delete();
      rd(2'd1, r); chk("t5_status", r, 32'h2);
      rd(2'd2, r); chk("t5_div", r, 32'd434);
      rd(2'd3, r); chk("t5_ctrl", r, 32'd1);
      lows = 0;
      repeat (40) begin
         @(negedge clk);
         if (o_tx !== 1'b1) lows++;
      end
      chk("t5_no_resume", 32'(lows), 32'd0);

      // Decode: non-hit addresses
      rda(30'h3FFF_FFFF, r); chk("nohit_rd", r, 32'd0);
      wra(30'h3FFF_FFFF, 32'd0, 4'b1111);
      wra(30'h3FFF_FFFC, 32'hAA, 4'b1111);
      wra(BASE + 30'd4, 32'hBB, 4'b1111);
      wra(BASE + 30'd6, 32'd3, 4'b1111);
      rd(2'd3, r); chk("nohit_ctrl", r, 32'd1);
      rd(2'd2, r); chk("nohit_div", r, 32'd434);
      rd(2'd1, r); chk("nohit_status", r, 32'h2);
      rda(BASE + 30'd5, r); chk("nohit_rd_near", r, 32'd0);

`ifdef UART_TX_IRQ_EN
      wr(2'd2, 32'd2, 4'b0011); mdiv = 16'd2;
      wr(2'd3, 32'd3, 4'b0001);
      rd(2'd3, r); chk("irq_ctrl", r, 32'd3);
      @(negedge clk);
      chk("irq_idle", {31'd0, o_irq}, 32'd1);
      b = 8'($urandom);
      wr(2'd0, {24'd0, b}, 4'b0001);
      for (int j = 0; j < 20; j++) begin
         @(negedge clk);
         chk("irq_frame", {31'd0, o_irq}, 32'd0);
      end
      @(negedge clk);
      chk("irq_stop_end", {31'd0, o_irq}, 32'd0);
      @(negedge clk);
      chk("irq_rise", {31'd0, o_irq}, 32'd1);
`else
      wr(2'd3, 32'd3, 4'b0001);
      rd(2'd3, r); chk("ctrl_bit1_zero", r, 32'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
